cpu: RTL and testbench

- Single-cycle, 32-bit MIPS-subset processor; one instruction retires per rising clock edge.
- Instruction memory is a flat 1024-word bus supplied by the parent (`instruction_stream`). Register file and data memory are internal.
- Top-level execution core for the processor test environment. It has no architectural outputs; verification observes internal state by hierarchical reference to `pc`, `regfile` and `dmem`.

---
 rtl/cpu.sv | 120 ++++++++++++
 tb/tb_cpu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// rtl/cpu.sv - single-cycle 32-bit MIPS-subset execution core
module cpu #(
  parameter int DMEM_WORDS = 256
) (
  input logic         clk,
  input logic         rst,
  input logic [32767:0] instruction_stream
);

  localparam int AW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGT   = 6'b000110;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // Architectural state keeps these exact names so the environment can probe it.
  logic [31:0] pc;
  logic [31:0] regfile [32];
  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] pc_d;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm, rs_val, rt_val, pc_plus4, sum, j_target;
  logic [AW-1:0] dm_idx;
  logic        rf_we, mem_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  // Fetch ignores pc[1:0]; only pc[11:2] selects, so addresses wrap at 4096.
  assign instr    = instruction_stream[{pc[11:2], 5'b00000} +: 32];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = {{16{instr[15]}}, instr[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : regfile[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : regfile[rt];
  assign pc_plus4 = pc + 32'd4;
  // One adder serves addi and the load/store effective address.
  assign sum      = rs_val + imm;
  assign dm_idx   = sum[AW+1:2];
  // Jump targets are byte addresses taken unshifted from the instruction.
  assign j_target = {pc_plus4[31:28], 2'b00, instr[25:0]};

  // Decode/execute: next pc plus the single register or memory write.
  always_comb begin
    pc_d   = pc_plus4;
    rf_we  = 1'b0;
    rf_wa  = 5'd0;
    rf_wd  = 32'd0;
    mem_we = 1'b0;
    case (op)
      OP_RTYPE: begin
        rf_wa = rd;
        case (funct)
          FN_ADD: begin rf_we = 1'b1; rf_wd = rs_val + rt_val; end
          FN_SUB: begin rf_we = 1'b1; rf_wd = rs_val - rt_val; end
          FN_AND: begin rf_we = 1'b1; rf_wd = rs_val & rt_val; end
          FN_OR:  begin rf_we = 1'b1; rf_wd = rs_val | rt_val; end
          FN_SLT: begin
            rf_we = 1'b1;
            rf_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
          end
          FN_JR:  pc_d = rs_val;
          default: ;
        endcase
      end
      OP_ADDI: begin rf_we = 1'b1; rf_wa = rt; rf_wd = sum; end
      OP_LW:   begin rf_we = 1'b1; rf_wa = rt; rf_wd = dmem[dm_idx]; end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) pc_d = pc_plus4 + imm;
      OP_BNE:  if (rs_val != rt_val) pc_d = pc_plus4 + imm;
      OP_BGT:  if ($signed(rs_val) > $signed(rt_val)) pc_d = pc_plus4 + imm;
      OP_J:    pc_d = j_target;
      OP_JAL:  begin pc_d = j_target; rf_we = 1'b1; rf_wa = 5'd31; rf_wd = pc_plus4; end
      default: ;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'd0;
    else     pc <= pc_d;
  end

  // Register file write port; $0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regfile[i] <= 32'd0;
    end else if (rf_we && (rf_wa != 5'd0)) begin
      regfile[rf_wa] <= rf_wd;
    end
  end

  // Data memory write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= 32'd0;
    end else if (mem_we) begin
      dmem[dm_idx] <= rt_val;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed self-checking bench for cpu
module tb_cpu;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [32767:0] imem = '0;

  int n_checks = 0;
  int n_errors = 0;

  cpu #(.DMEM_WORDS(256)) dut (
    .clk                (clk),
    .rst                (rst),
    .instruction_stream (imem)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    imem[32*idx +: 32] = w;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset, then release so the next rising edge executes word 0.
  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BGT = 6'b000110;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011;

  int pc_a [13] = '{4, 8, 12, 24, 36, 48, 52, 56, 60, 64, 60, 64, 60};
  int pc_c [4]  = '{4092, 4096, 4092, 4096};

  initial begin
    // Program A: immediates, taken branches, jumps, jal/jr loop.
    put(0,  enc_i(ADDI, 0, 1, 16'd5));
    put(1,  enc_i(ADDI, 0, 2, 16'd2));
    put(2,  enc_i(ADDI, 0, 3, 16'd7));
    put(3,  enc_i(BEQ, 1, 1, 16'd8));
    put(4,  enc_i(ADDI, 0, 4, 16'd1));
    put(5,  enc_i(ADDI, 0, 5, 16'd1));
    put(6,  enc_i(BNE, 1, 2, 16'd8));
    put(7,  enc_i(ADDI, 0, 5, 16'd2));
    put(8,  enc_i(ADDI, 0, 6, 16'd2));
    put(9,  enc_i(BGT, 3, 1, 16'd8));
    put(10, enc_i(ADDI, 0, 6, 16'd3));
    put(11, enc_i(ADDI, 0, 4, 16'd3));
    put(12, enc_j(J, 26'd52));
    put(13, enc_i(ADDI, 0, 7, 16'd13));
    put(14, enc_j(JAL, 26'd60));
    put(15, enc_i(ADDI, 0, 8, 16'd15));
    put(16, enc_r(31, 0, 0, 6'b001000));

    // Held reset with live stimulus and clock edges keeps state clear.
    rst = 1'b1;
    step(3);
    check_eq("rst_pc", dut.pc, 32'd0);
    check_eq("rst_r1", dut.regfile[1], 32'd0);
    check_eq("rst_r31", dut.regfile[31], 32'd0);

    restart();
    for (int k = 0; k < 13; k++) begin
      step(1);
      check_eq($sformatf("A_pc_%0d", k + 1), dut.pc, pc_a[k]);
      if (k == 2) begin
        check_eq("A_r1", dut.regfile[1], 32'd5);
        check_eq("A_r2", dut.regfile[2], 32'd2);
        check_eq("A_r3", dut.regfile[3], 32'd7);
      end
    end
    check_eq("A_r4", dut.regfile[4], 32'd0);
    check_eq("A_r5", dut.regfile[5], 32'd0);
    check_eq("A_r6", dut.regfile[6], 32'd0);
    check_eq("A_r7", dut.regfile[7], 32'd13);
    check_eq("A_r8", dut.regfile[8], 32'd15);
    check_eq("A_r31", dut.regfile[31], 32'd60);

    // Program B: ALU ops, negative operands, memory, no-ops.
    imem = '0;
    put(0,  enc_i(ADDI, 0, 1, 16'hFFFD));
    put(1,  enc_i(ADDI, 0, 2, 16'd6));
    put(2,  enc_r(1, 2, 3, 6'b100000));
    put(3,  enc_r(1, 2, 4, 6'b100010));
    put(4,  enc_r(1, 2, 5, 6'b100100));
    put(5,  enc_r(1, 2, 6, 6'b100101));
    put(6,  enc_i(ADDI, 0, 9, 16'd2));
    put(7,  enc_r(1, 9, 10, 6'b101010));
    put(8,  enc_r(9, 1, 11, 6'b101010));
    put(9,  enc_i(BGT, 1, 9, 16'd8));
    put(10, enc_i(ADDI, 0, 12, 16'd100));
    put(11, enc_i(SW, 12, 4, 16'hFFFC));
    put(12, enc_i(LW, 12, 13, 16'hFFFC));
    put(13, enc_i(ADDI, 0, 0, 16'd55));
    put(14, enc_i(BEQ, 1, 2, 16'd8));
    put(15, 32'h0000_0000);
    put(16, 32'hFFFF_FFFF);
    put(17, 32'h0022_1827);

    restart();
    for (int k = 1; k <= 18; k++) begin
      step(1);
      check_eq($sformatf("B_pc_%0d", k), dut.pc, 4 * k);
    end
    check_eq("B_add", dut.regfile[3], 32'd3);
    check_eq("B_sub", dut.regfile[4], 32'hFFFF_FFF7);
    check_eq("B_and", dut.regfile[5], 32'd4);
    check_eq("B_or", dut.regfile[6], 32'hFFFF_FFFF);
    check_eq("B_slt1", dut.regfile[10], 32'd1);
    check_eq("B_slt0", dut.regfile[11], 32'd0);
    check_eq("B_r12", dut.regfile[12], 32'd100);
    check_eq("B_dmem", dut.dmem[24], 32'hFFFF_FFF7);
    check_eq("B_lw", dut.regfile[13], 32'hFFFF_FFF7);
    check_eq("B_r0", dut.regfile[0], 32'd0);
    check_eq("B_r31", dut.regfile[31], 32'd0);

    // Asynchronous reset between edges clears state without waiting for a clock.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_pc", dut.pc, 32'd0);
    check_eq("async_r13", dut.regfile[13], 32'd0);
    check_eq("async_dmem", dut.dmem[24], 32'd0);

    // Program C: jump to the last word and wrap back to word 0.
    imem = '0;
    put(0,    enc_j(J, 26'd4092));
    put(1023, enc_i(ADDI, 0, 1, 16'd77));
    restart();
    for (int k = 0; k < 4; k++) begin
      step(1);
      check_eq($sformatf("C_pc_%0d", k + 1), dut.pc, pc_c[k]);
    end
    check_eq("C_r1", dut.regfile[1], 32'd77);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
